// File: rtl/resp_check_pkg.sv
// resp_check_pkg: shared state encoding and default sizing for the response checker
package resp_check_pkg;
  localparam int N_IN_DEF = 5;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
endpackage

// File: rtl/gold_table_sr.sv
// gold_table_sr: golden truth table loaded serially from the top, read by vector index
module gold_table_sr #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          CK,
  input  logic          reset,
  input  logic          shift_en,
  input  logic          bit_in,
  input  logic [AW-1:0] rd_idx,
  output logic          rd_bit
);
  logic [DEPTH-1:0] tbl;
  // new bits enter at the top so the first bit shifted ends in entry 0
  always_ff @(posedge CK or negedge reset)
    if (!reset) tbl <= '0;
    else if (shift_en) tbl <= {bit_in, tbl[DEPTH-1:1]};
  assign rd_bit = tbl[rd_idx];
endmodule

// File: rtl/exhaustive_resp_checker.sv
// exhaustive_resp_checker: compares a swept response stream against a golden table
module exhaustive_resp_checker
  import resp_check_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            gold_load,
  input  logic            gold_bit,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid,
  output logic            seq_err
);
  localparam int DEPTH = 2 ** N_IN;
  state_t        state;
  logic [N_IN:0] exp_idx;
  logic          gold_q;
  logic          xfer;
  logic          last;
  assign in_ready = state == CHECK;
  assign busy     = state == CHECK;
  assign done     = state == DONE;
  assign pass     = done && mismatch_cnt == '0 && !seq_err;
  assign xfer     = in_ready && in_valid;
  assign last     = exp_idx == (N_IN + 1)'(DEPTH - 1);
  gold_table_sr #(.DEPTH(DEPTH)) u_tbl (
    .CK       (CK),
    .reset    (reset),
    .shift_en (gold_load && !start && state != CHECK),
    .bit_in   (gold_bit),
    .rd_idx   (in_vec),
    .rd_bit   (gold_q)
  );
  // sweep control plus per-transfer mismatch, first-failure and ordering capture
  always_ff @(posedge CK or negedge reset)
    if (!reset) begin
      state            <= IDLE;
      exp_idx          <= '0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      seq_err          <= 1'b0;
    end else if (state != CHECK && start) begin
      state            <= CHECK;
      exp_idx          <= '0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      seq_err          <= 1'b0;
    end else if (xfer) begin
      if (in_resp != gold_q) begin
        mismatch_cnt <= mismatch_cnt + (N_IN + 1)'(1);
        if (!first_fail_valid) begin
          first_fail_vec   <= in_vec;
          first_fail_valid <= 1'b1;
        end
      end
      if ({1'b0, in_vec} != exp_idx) seq_err <= 1'b1;
      exp_idx <= exp_idx + (N_IN + 1)'(1);
      if (last) state <= DONE;
    end
endmodule

// File: doc/exhaustive_resp_checker.md
# exhaustive_resp_checker

Hardware reader for exhaustive single-output test sweeps: consumes a stream of (input vector, DUT response) pairs over a valid/ready handshake, compares each response against a serially loaded golden truth table, and reports mismatch count, first failing vector and a pass/fail verdict. It sits at the receiving end of the pattern sweep used in trojan-detection runs, replacing file capture with on-chip comparison.

## Interface
- N_IN, 5, input vector width; table depth DEPTH = 2**N_IN (32 by default)
- CK  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- gold_load  in  1  shift gold_bit into table this cycle
- gold_bit  in  1  golden response bit
- start  in  1  begin a sweep
- in_valid  in  1  pair present
- in_ready  out  1  checker accepts pair
- in_vec  in  N_IN  input vector of the pair
- in_resp  in  1  DUT response for in_vec
- busy  out  1  sweep in progress
- done  out  1  sweep complete, results stable
- pass  out  1  done, zero mismatches, no sequence error
- mismatch_cnt  out  N_IN+1  responses differing from golden
- first_fail_vec  out  N_IN  in_vec of first mismatch
- first_fail_valid  out  1  at least one mismatch recorded
- seq_err  out  1  sticky: a pair arrived out of ascending order

## Operation
- States: IDLE, CHECK, DONE. Reset -> IDLE.
- Golden load (IDLE or DONE only; ignored in CHECK): table <= {gold_bit, table[DEPTH-1:1]}. After DEPTH pulses the first bit shifted lands in entry 0 (entry k = golden response for vector k).
- IDLE/DONE + start -> CHECK; clears mismatch_cnt, first_fail_*, seq_err, accept counter (exp_idx) to 0. start in CHECK ignored. start and gold_load in the same cycle: start wins, bit not shifted.
- CHECK: in_ready = 1. Transfer when in_valid && in_ready.
  - Mismatch if in_resp != table[in_vec] (lookup by in_vec, not exp_idx): mismatch_cnt += 1; if first_fail_valid==0, capture first_fail_vec = in_vec, set first_fail_valid.
  - If in_vec != exp_idx: set seq_err (sticky until next start); comparison still performed.
  - exp_idx += 1 (N_IN+1 bits); transfer with exp_idx == DEPTH-1 -> DONE.
- DONE: done = 1, pass = (mismatch_cnt==0) && !seq_err; results held until next start or reset.
- mismatch_cnt max = DEPTH, fits N_IN+1 bits; no saturation logic needed.

## Timing
- in_ready, busy, done are decoded from registered state only (no input->output combinational path).
- Per-transfer update visible on outputs the cycle after the accepting edge; one pair per cycle sustained.
- Final transfer at edge t -> done=1, busy=0, in_ready=0 from edge t onward (visible cycle t+1); pass valid same cycle.
- start at edge t -> busy=1, counters cleared, in_ready=1 after edge t; a pair presented in the start cycle is not accepted.
- in_valid outside CHECK ignored; in_vec/in_resp are don't-care when in_valid=0.
- Reset values (any time, including mid-sweep): state IDLE, table all 0, in_ready 0, busy 0, done 0, pass 0, mismatch_cnt 0, first_fail_vec 0, first_fail_valid 0, seq_err 0.

## Structure
- Package resp_check_pkg: state enum (IDLE, CHECK, DONE), default N_IN constant.
- One sub-module, gold_table_sr: DEPTH-bit shift register with load enable and indexed read port; top holds FSM, counters and capture registers.

## Test plan
- Load 32 golden bits = 0xA5A5_5A5A (bit k = entry k), start, send vectors 0..31 with matching responses back-to-back -> done after 32 transfers, mismatch_cnt=0, pass=1, first_fail_valid=0.
- Same table, flip responses for vectors 7 and 20 -> mismatch_cnt=2, first_fail_vec=7, first_fail_valid=1, pass=0.
- Send vector 3 before 2 (all responses correct) -> seq_err=1, mismatch_cnt=0, pass=0, done still after 32 transfers.
- Randomized in_valid gaps (~50% duty) with correct data -> no lost or duplicated transfers, done exactly at 32nd transfer, pass=1.
- Assert reset low after 10 transfers -> all outputs and table 0 immediately; reload table and full sweep passes.
- Pulse gold_load during CHECK and start during CHECK -> table and counters unchanged; sweep completes with expected results.
